nrad_seq: RTL and testbench



---
 rtl/nrad_seq.sv | 154 +++++++++++++++
 tb/tb_nrad_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrad_seq.sv
// nrad_seq -- sequential non-restoring divider controller.
//
// Computes Q = X / Y and R = X % Y for unsigned operands. It performs one
// add/subtract step per clock, so a single CAS row is reused for N cycles.
// A final correction cycle brings a negative partial remainder back into
// range. The operation ends with a one-cycle done pulse.
//
// Optional feature macro: NRAD_DIVZERO_EN
//   When defined, accepting Y == 0 bypasses the iteration. One edge later it
//   produces Q = all ones, R = 0, dz = 1 and done = 1, and busy stays low.
//   When undefined, Y == 0 runs the normal sequence and dz is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only in IDLE
//   X [N-1:0]    unsigned dividend, captured on the accepting edge
//   Y [M-1:0]    unsigned divisor, captured on the accepting edge
//   busy         high while in ITER or CORR
//   done         one-cycle pulse, Q/R/dz valid
//   Q [N-1:0]    quotient register, held until the next completion
//   R [M-1:0]    remainder register, held until the next completion
//   dz           divide-by-zero flag, updated with each done pulse
//   o_dbg_state  current FSM state (debug observation only)
//
// Handshake: start is a request that is accepted on any rising edge where
// the block is IDLE and start = 1. While busy = 1, start is ignored and is
// not queued. The result is presented for exactly one cycle, with done = 1
// and busy = 0. A new start in that same cycle is accepted.

module nrad_seq #(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [M-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [M-1:0] R,
    output logic         dz,
    output logic [1:0]   o_dbg_state
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_CORR = 2'd2;
`ifdef NRAD_DIVZERO_EN
    localparam logic [1:0] S_DZ   = 2'd3;
`endif

    logic [1:0]    r_state;
    logic [M+1:0]  r_a;      // signed partial remainder
    logic [N-1:0]  r_s;      // dividend bits shifting out, quotient bits in
    logic [M+1:0]  r_d;      // zero-extended divisor
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_q;
    logic [M-1:0]  r_r;
    logic          r_done;
`ifdef NRAD_DIVZERO_EN
    logic          r_dz;
`endif

    logic [M+1:0]  w_shift;
    logic [M+1:0]  w_a_step;
    logic [M+1:0]  w_a_corr;

    // {A,S} << 1: the MSB of S enters the LSB of A. The top bit of A is
    // dropped. This is safe because |A| <= D, so 2A + 1 still fits in M+2 bits.
    assign w_shift  = {r_a[M:0], r_s[N-1]};
    // The sign of the old A selects the operation: subtract when A >= 0,
    // add when A < 0.
    assign w_a_step = r_a[M+1] ? (w_shift + r_d) : (w_shift - r_d);
    assign w_a_corr = r_a[M+1] ? (r_a + r_d) : r_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_s     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_done  <= 1'b0;
`ifdef NRAD_DIVZERO_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= '0;
                        r_s   <= X;
                        r_d   <= {2'b00, Y};
                        r_cnt <= '0;
`ifdef NRAD_DIVZERO_EN
                        if (Y == '0) r_state <= S_DZ;
                        else         r_state <= S_ITER;
`else
                        r_state <= S_ITER;
`endif
                    end
                end
                S_ITER: begin
                    r_a   <= w_a_step;
                    r_s   <= {r_s[N-2:0], ~w_a_step[M+1]};
                    r_cnt <= r_cnt + 1'b1;
                    // This is the last of N steps when the count is N-1
                    // before the increment.
                    if (r_cnt == CW'(N - 1)) r_state <= S_CORR;
                end
                S_CORR: begin
                    r_a     <= w_a_corr;
                    r_q     <= r_s;
                    r_r     <= w_a_corr[M-1:0];
                    r_done  <= 1'b1;
`ifdef NRAD_DIVZERO_EN
                    r_dz    <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
`ifdef NRAD_DIVZERO_EN
                    // S_DZ: report divide-by-zero without iterating.
                    r_q    <= '1;
                    r_r    <= '0;
                    r_dz   <= 1'b1;
                    r_done <= 1'b1;
`endif
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == S_ITER) || (r_state == S_CORR);
    assign done        = r_done;
    assign Q           = r_q;
    assign R           = r_r;
    assign o_dbg_state = r_state;
`ifdef NRAD_DIVZERO_EN
    assign dz          = r_dz;
`else
    assign dz          = 1'b0;
`endif

endmodule

// File: tb/tb_nrad_seq.sv
// Self-checking bench for nrad_seq (N=4, M=2).
module tb_nrad_seq;

  localparam int N = 4;
  localparam int M = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] X = '0;
  logic [M-1:0] Y = '0;
  logic         busy, done, dz;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic [1:0]   dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit check_en = 1'b0;

  nrad_seq #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .Q(Q), .R(R), .dz(dz),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // The model tracks the edges remaining until the result. It computes the
  // result arithmetically when the operation is accepted.
  int           m_rem = 0;
  bit           m_zpath = 1'b0;
  logic         m_done = 1'b0;
  logic [N-1:0] m_q = '0, p_q = '0;
  logic [M-1:0] m_r = '0, p_r = '0;
  logic         m_dz = 1'b0, p_dz = 1'b0;
  bit           m_known = 1'b1, p_known = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem   <= 0;
      m_zpath <= 1'b0;
      m_done  <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
      m_dz    <= 1'b0;
      m_known <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done  <= 1'b1;
          m_q     <= p_q;
          m_r     <= p_r;
          m_dz    <= p_dz;
          m_known <= p_known;
          m_zpath <= 1'b0;
        end
      end else if (start) begin
        if (Y != '0) begin
          p_q     <= N'(int'(X) / int'(Y));
          p_r     <= M'(int'(X) % int'(Y));
          p_dz    <= 1'b0;
          p_known <= 1'b1;
          m_rem   <= N + 1;
          m_zpath <= 1'b0;
        end else begin
`ifdef NRAD_DIVZERO_EN
          p_q     <= '1;
          p_r     <= '0;
          p_dz    <= 1'b1;
          p_known <= 1'b1;
          m_rem   <= 1;
          m_zpath <= 1'b1;
`else
          p_q     <= '0;
          p_r     <= '0;
          p_dz    <= 1'b0;
          p_known <= 1'b0;
          m_rem   <= N + 1;
          m_zpath <= 1'b0;
`endif
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      logic exp_busy;
      exp_busy = (m_rem > 0) && !m_zpath;
      tests++;
      if (busy !== exp_busy || done !== m_done || dz !== m_dz ||
          (busy === 1'b1 && done === 1'b1) ||
          (m_known && (Q !== m_q || R !== m_r))) begin
        fails++;
        $display("FAIL cyc_cmp t=%0t got/exp busy=%b/%b done=%b/%b dz=%b/%b Q=%0d/%0d R=%0d/%0d",
                 $time, busy, exp_busy, done, m_done, dz, m_dz, Q, m_q, R, m_r);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Returns at the negedge where done is seen. lat = number of edges waited.
  task automatic wait_done(input int budget, output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        lat = i;
        return;
      end
    end
  endtask

  task automatic do_op(input int x, input int y, output bit ok, output int lat);
    @(negedge clk);
    X = N'(x);
    Y = M'(y);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, ok, lat);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int lat;
    int d0;
    int last;

    #1 rst = 1'b1;
    #1 check_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_dz", int'(dz), 0);
    rst = 1'b0;

    // 13 / 3
    do_op(13, 3, ok, lat);
    chk("op13_3_done", int'(ok), 1);
    chk("op13_3_lat", lat, 5);
    chk("op13_3_Q", int'(Q), 4);
    chk("op13_3_R", int'(R), 1);
    chk("op13_3_dz", int'(dz), 0);

    do_op(15, 1, ok, lat);
    chk("op15_1_Q", int'(Q), 15);
    chk("op15_1_R", int'(R), 0);
    do_op(2, 3, ok, lat);
    chk("op2_3_Q", int'(Q), 0);
    chk("op2_3_R", int'(R), 2);

    // back-to-back sweep, each op started in the previous done cycle
    @(negedge clk);
    X = 4'd0;
    Y = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last = 0;
    for (int k = 0; k < 48; k++) begin
      wait_done(20, ok, lat);
      chk("sweep_done", int'(ok), 1);
      chk("sweep_Q", int'(Q), (k / 3) / (k % 3 + 1));
      chk("sweep_R", int'(R), (k / 3) % (k % 3 + 1));
      if (k > 0) chk("sweep_spacing", cyc - last, N + 2);
      last = cyc;
      if (k < 47) begin
        X = N'((k + 1) / 3);
        Y = M'((k + 1) % 3 + 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    // start while busy is ignored
    @(negedge clk);
    X = 4'd13;
    Y = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    X = 4'd7;
    Y = 2'd2;
    start = 1'b1;
    @(negedge clk);
    X = 4'd5;
    Y = 2'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, ok, lat);
    chk("ign_done", int'(ok), 1);
    chk("ign_Q", int'(Q), 4);
    chk("ign_R", int'(R), 1);
    repeat (8) @(negedge clk);
    chk("ign_one_pulse", done_cnt - d0, 1);

    // asynchronous reset mid-ITER
    @(negedge clk);
    X = 4'd11;
    Y = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_Q", int'(Q), 0);
    chk("arst_R", int'(R), 0);
    chk("arst_dz", int'(dz), 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("arst_no_done", done_cnt - d0, 0);
    do_op(11, 2, ok, lat);
    chk("post_rst_Q", int'(Q), 5);
    chk("post_rst_R", int'(R), 1);

    // divide by zero
    do_op(9, 0, ok, lat);
    chk("dz_done", int'(ok), 1);
`ifdef NRAD_DIVZERO_EN
    chk("dz_lat", lat, 1);
    chk("dz_Q", int'(Q), 15);
    chk("dz_R", int'(R), 0);
    chk("dz_flag", int'(dz), 1);
`else
    chk("dz_lat", lat, 5);
    chk("dz_flag", int'(dz), 0);
`endif
    do_op(9, 3, ok, lat);
    chk("after_dz_Q", int'(Q), 3);
    chk("after_dz_R", int'(R), 0);
    chk("after_dz_flag", int'(dz), 0);

    // randomized traffic: restarts, ignored starts, divide by zero
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      X = N'($urandom_range(0, 15));
      Y = M'($urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
